// File: rtl/vram_arbiter.sv
// vram_arbiter
// Single-port video RAM arbiter between the display fetch path and a host
// read/write port. The display path has priority and gets one fully
// pipelined read per cycle. The host is served in idle cycles, and after
// STARVE_MAX edges of waiting it is forced in ahead of the display. The
// display fetch displaced by a forced slot is dropped and counted.
//
// Ports
//   CLK, NRST                 clock, asynchronous active-low reset
//   DISP_REQ/DISP_ADDR        display read request and address
//   DISP_VALID/DISP_DATA      display read return, 2 cycles after grant
//   DISP_MISS/MISS_CNT        dropped-fetch pulse, saturating drop count
//   HOST_REQ/WE/ADDR/WDATA    host request; held until HOST_ACK
//   HOST_ACK/HOST_RDATA       write issued, or read data valid
//   MEM_EN/WE/ADDR/WDATA      synchronous SRAM command
//   MEM_RDATA                 SRAM read data, 1 cycle after the command

module vram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic              CLK,
    input  logic              NRST,
    input  logic              DISP_REQ,
    input  logic [ADDR_W-1:0] DISP_ADDR,
    output logic              DISP_VALID,
    output logic [DATA_W-1:0] DISP_DATA,
    output logic              DISP_MISS,
    output logic [7:0]        MISS_CNT,
    input  logic              HOST_REQ,
    input  logic              HOST_WE,
    input  logic [ADDR_W-1:0] HOST_ADDR,
    input  logic [DATA_W-1:0] HOST_WDATA,
    output logic              HOST_ACK,
    output logic [DATA_W-1:0] HOST_RDATA,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    localparam int WAIT_W = $clog2(STARVE_MAX + 1);

    // Tag that travels with each command so the read data returning two
    // edges later is steered to the port that issued it.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_HOST = 2'd2
    } tag_t;

    logic [WAIT_W-1:0] wait_cnt;
    logic              host_busy;
    tag_t              tag_s1;
    tag_t              tag_s2;

    logic              host_elig;
    logic              force_host;
    logic              grant_host;
    logic              grant_disp;
    logic              drop_disp;
    tag_t              tag_next;

    always_comb begin
        host_elig  = HOST_REQ && !host_busy;
        force_host = host_elig && (wait_cnt == WAIT_W'(STARVE_MAX));
        grant_host = force_host || (host_elig && !DISP_REQ);
        grant_disp = DISP_REQ && !force_host;
        drop_disp  = DISP_REQ && force_host;

        tag_next = TAG_NONE;
        if (grant_disp) begin
            tag_next = TAG_DISP;
        end else if (grant_host && !HOST_WE) begin
            tag_next = TAG_HOST;
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            wait_cnt   <= '0;
            host_busy  <= 1'b0;
            tag_s1     <= TAG_NONE;
            tag_s2     <= TAG_NONE;
            MEM_EN     <= 1'b0;
            MEM_WE     <= 1'b0;
            MEM_ADDR   <= '0;
            MEM_WDATA  <= '0;
            DISP_VALID <= 1'b0;
            DISP_DATA  <= '0;
            DISP_MISS  <= 1'b0;
            MISS_CNT   <= '0;
            HOST_ACK   <= 1'b0;
            HOST_RDATA <= '0;
        end else begin
            // Command stage
            MEM_EN    <= grant_host || grant_disp;
            MEM_WE    <= grant_host && HOST_WE;
            MEM_ADDR  <= grant_host ? HOST_ADDR :
                         (grant_disp ? DISP_ADDR : '0);
            MEM_WDATA <= (grant_host && HOST_WE) ? HOST_WDATA : '0;

            // Starvation counter only runs while an eligible host is
            // being passed over by the display.
            if (grant_host || !host_elig) begin
                wait_cnt <= '0;
            end else if (grant_disp) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            DISP_MISS <= drop_disp;
            if (drop_disp && (MISS_CNT != 8'hFF)) begin
                MISS_CNT <= MISS_CNT + 8'd1;
            end

            // Busy blocks a held HOST_REQ from being granted again; it
            // drops one edge after the acknowledge so the requester has
            // a cycle to release the request.
            if (grant_host) begin
                host_busy <= 1'b1;
            end else if (HOST_ACK) begin
                host_busy <= 1'b0;
            end

            // Read return pipeline
            tag_s1 <= tag_next;
            tag_s2 <= tag_s1;

            DISP_VALID <= (tag_s2 == TAG_DISP);
            if (tag_s2 == TAG_DISP) begin
                DISP_DATA <= MEM_RDATA;
            end

            // Writes acknowledge as issued; reads when their data returns.
            HOST_ACK <= (grant_host && HOST_WE) || (tag_s2 == TAG_HOST);
            if (tag_s2 == TAG_HOST) begin
                HOST_RDATA <= MEM_RDATA;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

    logic        CLK;
    logic        NRST;
    logic        DISP_REQ;
    logic [15:0] DISP_ADDR;
    logic        DISP_VALID;
    logic [15:0] DISP_DATA;
    logic        DISP_MISS;
    logic [7:0]  MISS_CNT;
    logic        HOST_REQ;
    logic        HOST_WE;
    logic [15:0] HOST_ADDR;
    logic [15:0] HOST_WDATA;
    logic        HOST_ACK;
    logic [15:0] HOST_RDATA;
    logic        MEM_EN;
    logic        MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [15:0] MEM_WDATA;
    logic [15:0] MEM_RDATA;

    int errors;
    int checks;

    vram_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(8)) dut (
        .CLK        (CLK),
        .NRST       (NRST),
        .DISP_REQ   (DISP_REQ),
        .DISP_ADDR  (DISP_ADDR),
        .DISP_VALID (DISP_VALID),
        .DISP_DATA  (DISP_DATA),
        .DISP_MISS  (DISP_MISS),
        .MISS_CNT   (MISS_CNT),
        .HOST_REQ   (HOST_REQ),
        .HOST_WE    (HOST_WE),
        .HOST_ADDR  (HOST_ADDR),
        .HOST_WDATA (HOST_WDATA),
        .HOST_ACK   (HOST_ACK),
        .HOST_RDATA (HOST_RDATA),
        .MEM_EN     (MEM_EN),
        .MEM_WE     (MEM_WE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_RDATA  (MEM_RDATA)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Synchronous SRAM model; unwritten words read back as their address.
    logic [15:0] mem [logic [15:0]];
    initial MEM_RDATA = 16'h0000;
    always @(posedge CLK) begin
        if (MEM_EN) begin
            if (MEM_WE) begin
                mem[MEM_ADDR] = MEM_WDATA;
            end else begin
                MEM_RDATA <= mem.exists(MEM_ADDR) ? mem[MEM_ADDR] : MEM_ADDR;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        NRST = 1'b0;
        DISP_REQ = 1'b0; DISP_ADDR = '0;
        HOST_REQ = 1'b0; HOST_WE = 1'b0; HOST_ADDR = '0; HOST_WDATA = '0;
        #1;
        checks++;
        if ({MEM_EN, MEM_WE, DISP_VALID, DISP_MISS, HOST_ACK} !== 5'b0 ||
            MEM_ADDR !== 16'h0 || MEM_WDATA !== 16'h0 || MISS_CNT !== 8'h0 ||
            DISP_DATA !== 16'h0 || HOST_RDATA !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: en=%b we=%b dv=%b miss=%b ack=%b cnt=%h, all required 0",
                     MEM_EN, MEM_WE, DISP_VALID, DISP_MISS, HOST_ACK, MISS_CNT);
        end
        #11;
        NRST = 1'b1;
        step();
        checks++;
        if (MEM_EN !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: MEM_EN=%b required 0", MEM_EN);
        end
    endtask

    task automatic test_display_stream();
        DISP_REQ = 1'b1;
        DISP_ADDR = 16'h0100;
        for (int c = 0; c < 14; c++) begin
            step();
            if (c < 10) begin
                checks++;
                if (MEM_EN !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 16'(16'h0100 + c)) begin
                    errors++;
                    $display("FAIL disp_cmd[%0d]: en=%b we=%b addr=%h required 1/0/%h",
                             c, MEM_EN, MEM_WE, MEM_ADDR, 16'(16'h0100 + c));
                end
            end
            checks++;
            if (c >= 2 && c < 12) begin
                if (DISP_VALID !== 1'b1 || DISP_DATA !== 16'(16'h0100 + c - 2)) begin
                    errors++;
                    $display("FAIL disp_data[%0d]: valid=%b data=%h required 1/%h",
                             c, DISP_VALID, DISP_DATA, 16'(16'h0100 + c - 2));
                end
            end else if (DISP_VALID !== 1'b0) begin
                errors++;
                $display("FAIL disp_idle[%0d]: valid=%b required 0", c, DISP_VALID);
            end
            DISP_REQ = (c + 1 < 10);
            DISP_ADDR = 16'(16'h0100 + c + 1);
        end
        DISP_REQ = 1'b0;
    endtask

    task automatic test_host_write();
        HOST_REQ = 1'b1; HOST_WE = 1'b1;
        HOST_ADDR = 16'h0040; HOST_WDATA = 16'hBEEF;
        step();
        checks++;
        if (MEM_EN !== 1'b1 || MEM_WE !== 1'b1 || MEM_ADDR !== 16'h0040 ||
            MEM_WDATA !== 16'hBEEF || HOST_ACK !== 1'b1) begin
            errors++;
            $display("FAIL host_write_cmd: en=%b we=%b addr=%h wdata=%h ack=%b required 1/1/0040/beef/1",
                     MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, HOST_ACK);
        end
        step();
        checks++;
        if (MEM_EN !== 1'b0 || HOST_ACK !== 1'b0) begin
            errors++;
            $display("FAIL host_write_no_reissue: en=%b ack=%b required 0/0", MEM_EN, HOST_ACK);
        end
        HOST_REQ = 1'b0; HOST_WE = 1'b0;
        step();
    endtask

    task automatic test_host_read();
        HOST_REQ = 1'b1; HOST_WE = 1'b0; HOST_ADDR = 16'h0040;
        step();
        checks++;
        if (MEM_EN !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 16'h0040 || HOST_ACK !== 1'b0) begin
            errors++;
            $display("FAIL host_read_cmd: en=%b we=%b addr=%h ack=%b required 1/0/0040/0",
                     MEM_EN, MEM_WE, MEM_ADDR, HOST_ACK);
        end
        step();
        checks++;
        if (MEM_EN !== 1'b0 || HOST_ACK !== 1'b0) begin
            errors++;
            $display("FAIL host_read_wait: en=%b ack=%b required 0/0", MEM_EN, HOST_ACK);
        end
        step();
        checks++;
        if (HOST_ACK !== 1'b1 || HOST_RDATA !== 16'hBEEF) begin
            errors++;
            $display("FAIL host_read_data: ack=%b rdata=%h required 1/beef", HOST_ACK, HOST_RDATA);
        end
        step();
        checks++;
        if (MEM_EN !== 1'b0 || HOST_ACK !== 1'b0) begin
            errors++;
            $display("FAIL host_read_no_regrant: en=%b ack=%b required 0/0", MEM_EN, HOST_ACK);
        end
        HOST_REQ = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        DISP_REQ = 1'b1; DISP_ADDR = 16'h0200;
        HOST_REQ = 1'b1; HOST_WE = 1'b1; HOST_ADDR = 16'h0055; HOST_WDATA = 16'h1234;
        for (int e = 1; e <= 9; e++) begin
            step();
            checks++;
            if (e < 9) begin
                if (MEM_EN !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 16'(16'h0200 + e - 1) ||
                    HOST_ACK !== 1'b0 || DISP_MISS !== 1'b0) begin
                    errors++;
                    $display("FAIL starve_disp[%0d]: en=%b we=%b addr=%h ack=%b miss=%b required 1/0/%h/0/0",
                             e, MEM_EN, MEM_WE, MEM_ADDR, HOST_ACK, DISP_MISS, 16'(16'h0200 + e - 1));
                end
            end else begin
                if (MEM_EN !== 1'b1 || MEM_WE !== 1'b1 || MEM_ADDR !== 16'h0055 ||
                    MEM_WDATA !== 16'h1234 || HOST_ACK !== 1'b1 || DISP_MISS !== 1'b1 ||
                    MISS_CNT !== 8'd1) begin
                    errors++;
                    $display("FAIL starve_force: en=%b we=%b addr=%h wdata=%h ack=%b miss=%b cnt=%0d required 1/1/0055/1234/1/1/1",
                             MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, HOST_ACK, DISP_MISS, MISS_CNT);
                end
            end
            DISP_ADDR = 16'(16'h0200 + e);
        end
        HOST_REQ = 1'b0;
        step();
        checks++;
        if (MEM_EN !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 16'h0209 ||
            DISP_MISS !== 1'b0 || MISS_CNT !== 8'd1) begin
            errors++;
            $display("FAIL starve_resume: en=%b we=%b addr=%h miss=%b cnt=%0d required 1/0/0209/0/1",
                     MEM_EN, MEM_WE, MEM_ADDR, DISP_MISS, MISS_CNT);
        end
        DISP_REQ = 1'b0;
        step();
        checks++;
        if (DISP_VALID !== 1'b0) begin
            errors++;
            $display("FAIL dropped_no_valid: valid=%b required 0", DISP_VALID);
        end
        step();
        checks++;
        if (DISP_VALID !== 1'b1 || DISP_DATA !== 16'h0209) begin
            errors++;
            $display("FAIL resume_data: valid=%b data=%h required 1/0209", DISP_VALID, DISP_DATA);
        end
        step();
    endtask

    task automatic test_saturation();
        int pulses;
        int last;
        int exp_cnt;
        pulses = 0;
        last = -1;
        DISP_REQ = 1'b1; DISP_ADDR = 16'h0300;
        HOST_REQ = 1'b1; HOST_WE = 1'b1; HOST_ADDR = 16'h0077; HOST_WDATA = 16'h5A5A;
        for (int cyc = 0; cyc < 4000 && pulses < 260; cyc++) begin
            step();
            if (DISP_MISS === 1'b1) begin
                pulses++;
                exp_cnt = (pulses + 1 > 255) ? 255 : pulses + 1;
                checks++;
                if (MISS_CNT !== 8'(exp_cnt) || HOST_ACK !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_count[%0d]: cnt=%0d ack=%b required %0d/1",
                             pulses, MISS_CNT, HOST_ACK, exp_cnt);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 10) begin
                        errors++;
                        $display("FAIL sat_spacing[%0d]: gap=%0d required 10", pulses, cyc - last);
                    end
                end
                last = cyc;
            end
        end
        checks++;
        if (pulses != 260) begin
            errors++;
            $display("FAIL sat_pulses: got %0d required 260 within budget", pulses);
        end
        DISP_REQ = 1'b0; HOST_REQ = 1'b0;
        step();
        step();
        checks++;
        if (MISS_CNT !== 8'd255 || DISP_MISS !== 1'b0) begin
            errors++;
            $display("FAIL sat_final: cnt=%0d miss=%b required 255/0", MISS_CNT, DISP_MISS);
        end
    endtask

    task automatic test_reset_midrun();
        DISP_REQ = 1'b1; DISP_ADDR = 16'h0105;
        step();
        DISP_REQ = 1'b0;
        checks++;
        if (MEM_EN !== 1'b1) begin
            errors++;
            $display("FAIL midrun_cmd: en=%b required 1", MEM_EN);
        end
        #2;
        NRST = 1'b0;
        #1;
        checks++;
        if (MEM_EN !== 1'b0 || MEM_ADDR !== 16'h0 || MISS_CNT !== 8'h0 ||
            DISP_VALID !== 1'b0 || HOST_ACK !== 1'b0 || DISP_DATA !== 16'h0) begin
            errors++;
            $display("FAIL midrun_async_clear: en=%b addr=%h cnt=%0d dv=%b ack=%b required all 0",
                     MEM_EN, MEM_ADDR, MISS_CNT, DISP_VALID, HOST_ACK);
        end
        step();
        NRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (DISP_VALID !== 1'b0 || HOST_ACK !== 1'b0 || MISS_CNT !== 8'h0) begin
                errors++;
                $display("FAIL no_stale[%0d]: dv=%b ack=%b cnt=%0d required 0/0/0",
                         i, DISP_VALID, HOST_ACK, MISS_CNT);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_display_stream();
        test_host_write();
        test_host_read();
        test_starvation();
        test_saturation();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
